// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg
// Shared definitions for the one-hot select sequencer:
//   - state_e      : FSM state encoding (ST_IDLE / ST_RUN)
//   - NCH          : number of select lines (fixed at 4)
//   - idx_to_onehot: 2-bit channel index -> 4-bit one-hot select vector
package mux_sel_pkg;

    localparam int NCH = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Convert a channel index into the matching one-hot select pattern
    function automatic logic [NCH-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [NCH-1:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mux_sel_dwell_cnt.sv
// mux_sel_dwell_cnt
// DW-bit dwell counter. Counts up while enabled and rolls back to zero after
// reaching the programmed limit (dwell-1). A synchronous clear overrides the
// enable. tc flags the last cycle of the current dwell.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (priority over en)
//   en         : advance the counter this cycle
//   limit      : terminal value (dwell-1)
//   tc         : high when the count equals limit
module mux_sel_dwell_cnt #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] limit,
    output logic          tc
);

    logic [DW-1:0] cnt_r;

    assign tc = (cnt_r == limit);

    // Dwell count register: clear, roll over at the limit, or increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (tc) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + {{(DW-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
// Generates round-robin one-hot select lines s0->s1->s2->s3 for a 4:1 mux,
// holding each select for a programmable dwell. Continuous or single-sweep
// operation, start/stop control and an end-of-sweep strobe.
// Optional build macro: MUX_SEL_PAUSE_EN adds a 'pause' input that freezes
// the sequence (counter, channel and select) while in RUN.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : begin sequencing (IDLE only)
//   stop           : abort sequencing, highest priority
//   mode           : 0 continuous, 1 single sweep (latched at start)
//   dwell[DW-1:0]  : cycles per select, 0 treated as 1 (latched at start)
//   pause          : (MUX_SEL_PAUSE_EN only) hold the current select
//   s0..s3         : registered one-hot select lines
//   ch_idx[1:0]    : active select index, 0 in IDLE
//   busy           : high while in RUN
//   sweep_done     : one-cycle pulse after s3's final dwell cycle
module mux_sel_sequencer #(
    parameter int DW  = 8,
    parameter int NCH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          mode,
    input  logic [DW-1:0] dwell,
`ifdef MUX_SEL_PAUSE_EN
    input  logic          pause,
`endif
    output logic          s0,
    output logic          s1,
    output logic          s2,
    output logic          s3,
    output logic [1:0]    ch_idx,
    output logic          busy,
    output logic          sweep_done
);

    import mux_sel_pkg::*;

    state_e           state_r, state_s;
    logic [NCH-1:0]   sel_r, sel_s;
    logic [1:0]       ch_idx_r, ch_idx_s;
    logic             busy_r, busy_s;
    logic             sweep_done_r, sweep_done_s;
    logic             mode_r, mode_s;
    logic [DW-1:0]    dwell_r, dwell_s;
    logic             pause_s;
    logic             tc_s;
    logic             cnt_clr_s;
    logic             cnt_en_s;
    logic [DW-1:0]    limit_s;

`ifdef MUX_SEL_PAUSE_EN
    assign pause_s = pause;
`else
    assign pause_s = 1'b0;
`endif

    // Counter restarts on every entry into RUN because it is held clear in IDLE
    // and on stop; it only runs while sequencing and not paused.
    assign cnt_clr_s = (state_r == ST_IDLE) || stop;
    assign cnt_en_s  = (state_r == ST_RUN) && !pause_s;
    assign limit_s   = dwell_r - {{(DW-1){1'b0}}, 1'b1};

    mux_sel_dwell_cnt #(
        .DW (DW)
    ) u_dwell_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .limit (limit_s),
        .tc    (tc_s)
    );

    // Next-state and next-output logic for the IDLE/RUN sequencer
    always_comb begin
        state_s      = state_r;
        sel_s        = sel_r;
        ch_idx_s     = ch_idx_r;
        busy_s       = busy_r;
        sweep_done_s = 1'b0;
        mode_s       = mode_r;
        dwell_s      = dwell_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_s  = ST_RUN;
                    mode_s   = mode;
                    dwell_s  = (dwell == '0) ? {{(DW-1){1'b0}}, 1'b1} : dwell;
                    ch_idx_s = 2'd0;
                    sel_s    = idx_to_onehot(2'd0);
                    busy_s   = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                    sel_s    = '0;
                    ch_idx_s = 2'd0;
                    busy_s   = 1'b0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_s  = ST_IDLE;
                    sel_s    = '0;
                    ch_idx_s = 2'd0;
                    busy_s   = 1'b0;
                end else if (tc_s && !pause_s) begin
                    if (ch_idx_r == 2'd3) begin
                        // End of s3's dwell: strobe, then wrap or finish
                        sweep_done_s = 1'b1;
                        ch_idx_s     = 2'd0;
                        if (mode_r) begin
                            state_s = ST_IDLE;
                            sel_s   = '0;
                            busy_s  = 1'b0;
                        end else begin
                            state_s = ST_RUN;
                            sel_s   = idx_to_onehot(2'd0);
                            busy_s  = 1'b1;
                        end
                    end else begin
                        ch_idx_s = ch_idx_r + 2'd1;
                        sel_s    = idx_to_onehot(ch_idx_r + 2'd1);
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                sel_s    = '0;
                ch_idx_s = 2'd0;
                busy_s   = 1'b0;
            end
        endcase
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            sel_r        <= '0;
            ch_idx_r     <= 2'd0;
            busy_r       <= 1'b0;
            sweep_done_r <= 1'b0;
            mode_r       <= 1'b0;
            dwell_r      <= '0;
        end else begin
            state_r      <= state_s;
            sel_r        <= sel_s;
            ch_idx_r     <= ch_idx_s;
            busy_r       <= busy_s;
            sweep_done_r <= sweep_done_s;
            mode_r       <= mode_s;
            dwell_r      <= dwell_s;
        end
    end

    assign s0         = sel_r[0];
    assign s1         = sel_r[1];
    assign s2         = sel_r[2];
    assign s3         = sel_r[3];
    assign ch_idx     = ch_idx_r;
    assign busy       = busy_r;
    assign sweep_done = sweep_done_r;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer
// Directed bench for mux_sel_sequencer. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
// "Cycle c" is the c-th cycle after the edge that accepted start.
module tb_mux_sel_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] dwell;
`ifdef MUX_SEL_PAUSE_EN
    logic       pause;
`endif
    logic       s0, s1, s2, s3;
    logic [1:0] ch_idx;
    logic       busy;
    logic       sweep_done;

    int n_total = 0;
    int n_pass  = 0;

    mux_sel_sequencer #(.DW(8), .NCH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .dwell      (dwell),
`ifdef MUX_SEL_PAUSE_EN
        .pause      (pause),
`endif
        .s0         (s0),
        .s1         (s1),
        .s2         (s2),
        .s3         (s3),
        .ch_idx     (ch_idx),
        .busy       (busy),
        .sweep_done (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end else begin
            n_pass++;
        end
    endtask

    // Compare all sequencer outputs against one expected cycle
    task automatic chk_cyc(input string tag, input logic [3:0] e_sel, input logic [1:0] e_idx,
                           input logic e_busy, input logic e_sd);
        chk({tag, ".sel"},  {28'd0, s3, s2, s1, s0}, {28'd0, e_sel});
        chk({tag, ".idx"},  {30'd0, ch_idx}, {30'd0, e_idx});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
        chk({tag, ".sd"},   {31'd0, sweep_done}, {31'd0, e_sd});
    endtask

    function automatic logic [3:0] oh(input int idx);
        logic [3:0] v;
        v = 4'b0001;
        return v << idx;
    endfunction

    // Issue a start pulse; returns at the falling edge of cycle 1
    task automatic do_start(input logic m, input logic [7:0] d);
        start = 1'b1;
        mode  = m;
        dwell = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic go_idle();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int ch;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 1'b0;
        dwell = 8'd0;
`ifdef MUX_SEL_PAUSE_EN
        pause = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_cyc("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_cyc("idle_after_reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Continuous, dwell=3; start pulse and dwell change during RUN ignored
        do_start(1'b0, 8'd3);
        for (int c = 1; c <= 26; c++) begin
            ch = ((c - 1) % 12) / 3;
            chk_cyc($sformatf("cont3_c%0d", c), oh(ch), ch[1:0], 1'b1, (c == 13 || c == 25));
            start = (c == 5);
            dwell = (c >= 5) ? 8'd7 : 8'd3;
            @(negedge clk);
        end
        start = 1'b0;
        go_idle();
        chk_cyc("cont3_stopped", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single sweep, dwell=2
        do_start(1'b1, 8'd2);
        for (int c = 1; c <= 8; c++) begin
            ch = (c - 1) / 2;
            chk_cyc($sformatf("single2_c%0d", c), oh(ch), ch[1:0], 1'b1, 1'b0);
            @(negedge clk);
        end
        chk_cyc("single2_done", 4'b0000, 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk_cyc("single2_after", 4'b0000, 2'd0, 1'b0, 1'b0);

        // dwell=0 behaves as dwell=1
        do_start(1'b0, 8'd0);
        for (int c = 1; c <= 9; c++) begin
            ch = (c - 1) % 4;
            chk_cyc($sformatf("dwell0_c%0d", c), oh(ch), ch[1:0], 1'b1, (c == 5 || c == 9));
            @(negedge clk);
        end
        go_idle();

        // Stop during s1 dwell (cycle 5 with dwell=3)
        do_start(1'b0, 8'd3);
        repeat (4) @(negedge clk);
        chk_cyc("stop_s1_pre", 4'b0010, 2'd1, 1'b1, 1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk_cyc("stop_s1", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Stop coinciding with the s3->s0 wrap (dwell=1, cycle 4)
        do_start(1'b0, 8'd1);
        repeat (3) @(negedge clk);
        chk_cyc("stop_wrap_pre", 4'b1000, 2'd3, 1'b1, 1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk_cyc("stop_wrap", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Start and stop together in IDLE: stays IDLE
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk_cyc("start_stop_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-RUN while s2 is active (cycle 7, dwell=3)
        do_start(1'b0, 8'd3);
        repeat (6) @(negedge clk);
        chk_cyc("rst_pre", 4'b0100, 2'd2, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_cyc("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_cyc("rst_release_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

`ifdef MUX_SEL_PAUSE_EN
        // Pause for 5 cycles during s2 with dwell=4: s2 held cycles 9..17
        do_start(1'b0, 8'd4);
        for (int c = 1; c <= 19; c++) begin
            ch = (c <= 4) ? 0 : (c <= 8) ? 1 : (c <= 17) ? 2 : 3;
            chk_cyc($sformatf("pause_c%0d", c), oh(ch), ch[1:0], 1'b1, 1'b0);
            pause = (c >= 10 && c <= 14) || (c == 19);
            stop  = (c == 19);
            @(negedge clk);
        end
        pause = 1'b0;
        stop  = 1'b0;
        chk_cyc("pause_stop", 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
Upstream control stage for the 4-to-1 one-hot-select mux. It generates the one-hot select lines s3..s0 and steps round-robin s0→s1→s2→s3. Each select is held for a programmable dwell time. Supports continuous or single-sweep operation, start/stop pulses, and an end-of-sweep strobe for downstream capture logic.

Parameters:
DW, 8, width of dwell input and internal dwell counter
NCH, 4, number of select lines; fixed at 4, not to be overridden

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  begin sequencing; sampled only in IDLE
stop  input  1  abort sequencing; highest priority
mode  input  1  0 = continuous, 1 = single sweep; latched at start
dwell  input  DW  cycles each select is held; latched at start; 0 is treated as 1
s0  output  1  select line 0 (one-hot), registered
s1  output  1  select line 1, registered
s2  output  1  select line 2, registered
s3  output  1  select line 3, registered
ch_idx  output  2  index of the active select; 0 in IDLE
busy  output  1  high while in RUN
sweep_done  output  1  one-cycle pulse at completion of each s3 dwell

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, s3..s0 = 0000, ch_idx = 0, busy = 0, sweep_done = 0, dwell counter = 0, latched mode/dwell = 0. Reset released mid-sweep restarts in IDLE.
- FSM states: IDLE, RUN. All outputs are registered.
- IDLE: all selects 0.
  - start=1 at edge k latches mode and dwell (dwell 0 → 1), enters RUN, sets s0=1, ch_idx=0, busy=1.
  - Outputs are visible after edge k; latency is 1 cycle.
- RUN:
  - cnt increments each cycle.
  - When cnt == D-1: cnt ← 0, ch_idx ← ch_idx+1 (3 wraps to 0), and the select moves to the new one-hot position.
  - Each select is high for exactly D consecutive cycles; a full sweep is 4·D cycles.
  - Exactly one of s3..s0 is high in every RUN cycle; the selects are never 0000 and never multi-hot during RUN.
- Wrap (advance from ch_idx 3):
  - sweep_done = 1 for exactly the one cycle following s3's final cycle.
  - Continuous mode: s0 re-asserts in that same cycle.
  - Single-sweep mode: returns to IDLE in that cycle (selects 0000, busy 0).
- stop=1 in RUN: next cycle is IDLE with selects 0000 and no sweep_done, even when it coincides with a wrap.
- stop=1 in IDLE: no effect. stop and start both high in IDLE: stop wins, stays IDLE.
- start in RUN: ignored. dwell/mode changes in RUN: ignored until the next start.
- D = 1: selects rotate every cycle; sweep_done pulses every 4 cycles in continuous mode.
- Counter width is DW, so the maximum dwell is 2^DW − 1 with no overflow.

Optional Feature:
- Macro: MUX_SEL_PAUSE_EN.
- Defined: adds input port pause (1 bit). While pause=1 in RUN:
  - cnt and ch_idx freeze; the current select is held.
  - stop still takes effect.
  - sweep_done is not generated while paused.
  - pause has no effect in IDLE.
- Undefined: the pause port is absent and behaviour is exactly as above.

Decomposition:
- Shared package/header mux_sel_pkg holds:
  - state encodings ST_IDLE = 1'b0, ST_RUN = 1'b1
  - NCH = 4
  - function idx_to_onehot (2-bit index → 4-bit one-hot)
- One natural sub-module: mux_sel_dwell_cnt. It provides the DW-bit counter with clear, enable and a terminal-count flag (cnt == D-1).
- The FSM and one-hot registers stay in the top module.

Test Plan:
- Reset: rst_n=0 mid-RUN with s2=1 → s3..s0 = 0000, busy = 0, ch_idx = 0 immediately (asynchronous); after release the block stays IDLE with no start.
- Continuous, dwell=3: start pulse → s0 high cycles 1-3, s1 4-6, s2 7-9, s3 10-12, s0 again at 13. sweep_done high only in cycle 13, then again in cycle 25.
- Single sweep, dwell=2: start with mode=1 → 8 RUN cycles, then sweep_done=1 with selects 0000 and busy 0 in the same cycle; s0 does not re-assert.
- dwell=0: start → behaves as dwell=1, selects rotate every cycle, sweep_done every 4th cycle.
- stop during s1 dwell, and stop coinciding with the s3→s0 wrap → IDLE next cycle with no sweep_done. start asserted during RUN and a dwell change to 7 during RUN → timing unaffected.
- MUX_SEL_PAUSE_EN, dwell=4: pause high for 5 cycles during s2 → s2 held for 4+5 = 9 cycles, ch_idx frozen at 2; stop during pause → IDLE next cycle.
